// File: rtl/oversample_filter.sv
// rtl/oversample_filter.sv - oversampling window averager feeding the pid_core sample input
//
// Accumulates 2^os_mode signed samples and emits their floor average as a
// single-cycle valid pulse.
//
// Ports:
//   clk_in          system clock
//   reset_n_in      asynchronous active-low reset
//   data_in         signed ADC sample
//   data_valid_in   one cycle per sample
//   os_mode_in      requested log2 oversample ratio (clamped to MAX_OSM)
//   clear_in        discard the partial window
//   update_en_in    enables update_in
//   update_in       loads os_mode_in when update_en_in is high
//   data_out        signed window average, held between pulses
//   data_valid_out  one-cycle pulse per completed window
module oversample_filter #(
    parameter int W_IN    = 16,
    parameter int W_OUT   = 18,
    parameter int W_OSM   = 4,
    parameter int MAX_OSM = 10
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic signed [W_IN-1:0]  data_in,
    input  logic                    data_valid_in,
    input  logic [W_OSM-1:0]        os_mode_in,
    input  logic                    clear_in,
    input  logic                    update_en_in,
    input  logic                    update_in,
    output logic signed [W_OUT-1:0] data_out,
    output logic                    data_valid_out
);

    // Sum of 2^MAX_OSM samples of W_IN bits always fits in W_IN+MAX_OSM bits.
    localparam int W_ACC = W_IN + MAX_OSM;
    localparam int W_CNT = $clog2((1 << MAX_OSM) + 1);
    localparam logic [W_OSM-1:0] MAX_OSM_V = W_OSM'(MAX_OSM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SEND
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [W_ACC-1:0] r_sum;
    logic signed [W_ACC-1:0] w_sum_nxt;
    logic signed [W_ACC-1:0] w_din_ext;
    logic signed [W_ACC-1:0] w_sum_add;
    logic signed [W_ACC-1:0] w_shifted;
    logic [W_CNT-1:0]        r_count;
    logic [W_CNT-1:0]        w_count_nxt;
    logic [W_CNT-1:0]        w_count_add;
    logic [W_CNT-1:0]        w_n;
    logic [W_OSM-1:0]        r_os_mode;
    logic [W_OSM-1:0]        w_os_mode_nxt;
    logic [W_OSM-1:0]        w_os_mode_clamped;
    logic signed [W_OUT-1:0] r_data_out;
    logic signed [W_OUT-1:0] w_data_out_nxt;
    logic                    w_window_done;

    assign w_din_ext = W_ACC'(data_in);

    // IDLE and SEND both hold an empty window, so a sample there starts fresh.
    assign w_sum_add   = (r_state == ST_ACCUM) ? (r_sum + w_din_ext) : w_din_ext;
    assign w_count_add = (r_state == ST_ACCUM) ? (r_count + W_CNT'(1)) : W_CNT'(1);

    assign w_n           = W_CNT'(1) << r_os_mode;
    assign w_window_done = (w_count_add == w_n);

    // Arithmetic shift gives floor toward -inf for negative sums.
    assign w_shifted = w_sum_add >>> r_os_mode;

    assign w_os_mode_clamped = (os_mode_in > MAX_OSM_V) ? MAX_OSM_V : os_mode_in;

    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_count_nxt    = r_count;
        w_os_mode_nxt  = r_os_mode;
        w_data_out_nxt = r_data_out;

        if (update_in && update_en_in) begin
            w_os_mode_nxt = w_os_mode_clamped;
            w_sum_nxt     = '0;
            w_count_nxt   = '0;
            w_state_nxt   = ST_IDLE;
        end else if (clear_in) begin
            w_sum_nxt   = '0;
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (data_valid_in) begin
            if (w_window_done) begin
                w_data_out_nxt = W_OUT'(w_shifted);
                w_sum_nxt      = '0;
                w_count_nxt    = '0;
                w_state_nxt    = ST_SEND;
            end else begin
                w_sum_nxt   = w_sum_add;
                w_count_nxt = w_count_add;
                w_state_nxt = ST_ACCUM;
            end
        end else if (r_state == ST_SEND) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_IDLE;
            r_sum      <= '0;
            r_count    <= '0;
            r_os_mode  <= '0;
            r_data_out <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sum      <= w_sum_nxt;
            r_count    <= w_count_nxt;
            r_os_mode  <= w_os_mode_nxt;
            r_data_out <= w_data_out_nxt;
        end
    end

    assign data_out       = r_data_out;
    assign data_valid_out = (r_state == ST_SEND);

endmodule

// File: tb/tb_oversample_filter.sv
// tb/tb_oversample_filter.sv - directed self-checking bench for oversample_filter
module tb_oversample_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n;
    logic signed [15:0] din;
    logic               din_v;
    logic [3:0]         osm;
    logic               clr;
    logic               upd_en;
    logic               upd;
    logic signed [17:0] dout;
    logic               dout_v;

    int total = 0;
    int bad   = 0;

    int          q_s[$];
    logic [17:0] pd[0:3];
    int          pc[0:3];
    int          n_p;

    oversample_filter dut (
        .clk_in         (clk),
        .reset_n_in     (reset_n),
        .data_in        (din),
        .data_valid_in  (din_v),
        .os_mode_in     (osm),
        .clear_in       (clr),
        .update_en_in   (upd_en),
        .update_in      (upd),
        .data_out       (dout),
        .data_valid_out (dout_v)
    );

    // Drives q_s back-to-back (first sample = cycle 1), then gap idle cycles,
    // recording each output pulse and the cycle it appeared on.
    task automatic feed(input int gap);
        n_p = 0;
        for (int i = 0; i < 4; i++) begin
            pd[i] = 18'h2AAAA;
            pc[i] = -1;
        end
        for (int k = 0; k < q_s.size() + gap; k++) begin
            @(negedge clk);
            if (dout_v === 1'b1) begin
                if (n_p < 4) begin
                    pd[n_p] = dout;
                    pc[n_p] = k + 1;
                end
                n_p++;
            end
            if (k < q_s.size()) begin
                din_v = 1'b1;
                din   = 16'(q_s[k]);
            end else begin
                din_v = 1'b0;
            end
        end
    endtask

    task automatic set_mode(input logic [3:0] m);
        @(negedge clk);
        osm    = m;
        upd_en = 1'b1;
        upd    = 1'b1;
        @(negedge clk);
        upd    = 1'b0;
        upd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        din = '0; din_v = 1'b0; osm = '0; clr = 1'b0; upd_en = 1'b0; upd = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (dout !== 18'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dout); end
        total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", dout_v); end
        reset_n = 1'b1;
        @(negedge clk);
        total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%b want=0", dout_v); end
    endtask

    task automatic test_n1();
        set_mode(4'd0);
        q_s = '{100, -5};
        feed(2);
        total++; if (n_p !== 2) begin bad++; $display("FAIL n1_pulses got=%0d want=2", n_p); end
        total++; if (pd[0] !== 18'd100 || pc[0] !== 2) begin bad++; $display("FAIL n1_first got=%h@%0d want=00064@2", pd[0], pc[0]); end
        total++; if (pd[1] !== 18'h3FFFB || pc[1] !== 3) begin bad++; $display("FAIL n1_second got=%h@%0d want=3fffb@3", pd[1], pc[1]); end
        total++; if (dout !== 18'h3FFFB) begin bad++; $display("FAIL n1_hold got=%h want=3fffb", dout); end
    endtask

    task automatic test_avg4();
        set_mode(4'd2);
        q_s = '{1, 2, 3, 6};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd3 || pc[0] !== 5) begin bad++; $display("FAIL avg4_pos got=%0d:%h@%0d want=1:00003@5", n_p, pd[0], pc[0]); end
        q_s = '{-1, -1, -1, -2};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'h3FFFE) begin bad++; $display("FAIL avg4_floor got=%0d:%h want=1:3fffe", n_p, pd[0]); end
    endtask

    task automatic test_extremes();
        set_mode(4'd3);
        q_s = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'h38000) begin bad++; $display("FAIL ext_min got=%0d:%h want=1:38000", n_p, pd[0]); end
        q_s = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'h07FFF) begin bad++; $display("FAIL ext_max got=%0d:%h want=1:07fff", n_p, pd[0]); end
    endtask

    task automatic test_update();
        set_mode(4'd2);
        q_s = '{7, 7};
        feed(2);
        set_mode(4'd1);
        total++; if (n_p !== 0 || dout_v !== 1'b0) begin bad++; $display("FAIL upd_partial got=%0d,%b want=0,0", n_p, dout_v); end
        // update without enable must be ignored
        @(negedge clk);
        osm = 4'd0; upd = 1'b1; upd_en = 1'b0;
        @(negedge clk);
        upd = 1'b0;
        q_s = '{10, 20};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd15 || pc[0] !== 3) begin bad++; $display("FAIL upd_mode1 got=%0d:%h@%0d want=1:0000f@3", n_p, pd[0], pc[0]); end
        // sample coincident with an update is dropped
        @(negedge clk);
        din = 16'sd50; din_v = 1'b1; osm = 4'd1; upd = 1'b1; upd_en = 1'b1;
        @(negedge clk);
        din_v = 1'b0; upd = 1'b0; upd_en = 1'b0;
        q_s = '{10, 20};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd15 || pc[0] !== 3) begin bad++; $display("FAIL upd_drop got=%0d:%h@%0d want=1:0000f@3", n_p, pd[0], pc[0]); end
        // clamp: 14 -> 10, so 1024 samples per pulse
        set_mode(4'd14);
        q_s.delete();
        for (int i = 0; i < 1023; i++) q_s.push_back(3);
        q_s.push_back(1027);
        feed(3);
        total++; if (n_p !== 1 || pd[0] !== 18'd4 || pc[0] !== 1025) begin bad++; $display("FAIL upd_clamp got=%0d:%h@%0d want=1:00004@1025", n_p, pd[0], pc[0]); end
    endtask

    task automatic test_clear_reset();
        set_mode(4'd1);
        @(negedge clk);
        din = 16'sd9; din_v = 1'b1;
        @(negedge clk);
        din = 16'sd11; clr = 1'b1;
        @(negedge clk);
        din_v = 1'b0; clr = 1'b0;
        total++; if (dout_v !== 1'b0) begin bad++; $display("FAIL clr_nopulse got=%b want=0", dout_v); end
        q_s = '{4, 6};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd5 || pc[0] !== 3) begin bad++; $display("FAIL clr_next got=%0d:%h@%0d want=1:00005@3", n_p, pd[0], pc[0]); end
        // async reset while a pulse is on the outputs
        @(negedge clk);
        din = 16'sd4; din_v = 1'b1;
        @(negedge clk);
        din = 16'sd6;
        @(posedge clk);
        #2;
        total++; if (dout_v !== 1'b1 || dout !== 18'd5) begin bad++; $display("FAIL rst_pre got=%b:%h want=1:00005", dout_v, dout); end
        reset_n = 1'b0;
        din_v   = 1'b0;
        #1;
        total++; if (dout !== 18'h0 || dout_v !== 1'b0) begin bad++; $display("FAIL rst_async got=%b:%h want=0:00000", dout_v, dout); end
        @(negedge clk);
        reset_n = 1'b1;
        // os_mode returns to 0 after reset
        q_s = '{77};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd77 || pc[0] !== 2) begin bad++; $display("FAIL rst_mode0 got=%0d:%h@%0d want=1:0004d@2", n_p, pd[0], pc[0]); end
        set_mode(4'd1);
        q_s = '{8, 13};
        feed(2);
        total++; if (n_p !== 1 || pd[0] !== 18'd10 || pc[0] !== 3) begin bad++; $display("FAIL rst_window got=%0d:%h@%0d want=1:0000a@3", n_p, pd[0], pc[0]); end
    endtask

    task automatic test_back_to_back();
        set_mode(4'd2);
        q_s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        feed(3);
        total++; if (n_p !== 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", n_p); end
        total++; if (pd[0] !== 18'd2 || pc[0] !== 5) begin bad++; $display("FAIL b2b_w1 got=%h@%0d want=00002@5", pd[0], pc[0]); end
        total++; if (pd[1] !== 18'd6 || pc[1] !== 9) begin bad++; $display("FAIL b2b_w2 got=%h@%0d want=00006@9", pd[1], pc[1]); end
        total++; if (pd[2] !== 18'd10 || pc[2] !== 13) begin bad++; $display("FAIL b2b_w3 got=%h@%0d want=0000a@13", pd[2], pc[2]); end
    endtask

    initial begin
        test_reset();
        test_n1();
        test_avg4();
        test_extremes();
        test_update();
        test_clear_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
